imem_responder: RTL and testbench

- Instruction-memory responder: the slave end of the fetch handshake driven by the core's instruction-fetch FSM.
- Holds a word-addressed instruction array, loadable through a program port.
- Answers fetch requests after a programmable number of wait states, so the fetch FSM's stall paths are exercised.
- Sits between the IF stage fetch controller and the instruction storage; replaces the ideal zero-latency memory model.

---
 rtl/imem_responder.sv | 139 +++++++++++++
 tb/tb_imem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory fetch responder with programmable wait states
// Optional: define IMEM_RESPONDER_STATS_EN to add stat_accepts/stat_flushes/stat_errors counters.
module imem_responder #(
    parameter int          DEPTH          = 1024,
    parameter int          WAIT_CYCLES    = 2,
    parameter int          STARTUP_CYCLES = 4,
    parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
`ifdef IMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]              stat_accepts,
    output logic [31:0]              stat_flushes,
    output logic [31:0]              stat_errors
`endif
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] START_INIT = 4'(STARTUP_CYCLES - 1);
    localparam logic [3:0] WAIT_INIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_STARTUP, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] pend_data;
    logic        pend_err;
    logic        accept;
    logic        fetch_err;
    logic [31:0] fetch_data;
    logic        load_from_pend;

    assign fetch_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
    assign fetch_data = fetch_err ? NOP_WORD : mem[req_addr[AW+1:2]];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_ready      = ((state_q == S_IDLE) || (state_q == S_RESP)) && !flush;
        accept         = req_valid && req_ready;
        rsp_valid      = (state_q == S_RESP) && !flush;
        load_from_pend = (state_q == S_WAIT) && !flush && (cnt_q == 4'd0);
        case (state_q)
            S_STARTUP: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_IDLE, S_RESP: begin
                // flush already masks req_ready, so accept implies no flush
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush)               state_d = S_IDLE;
                else if (cnt_q == 4'd0)  state_d = S_RESP;
                else                     cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STARTUP;
            cnt_q   <= START_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fetch result is captured at accept; rsp_data only moves when the response is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
            pend_data <= 32'd0;
            pend_err  <= 1'b0;
        end else begin
            if (accept && (WAIT_CYCLES == 0)) begin
                rsp_data <= fetch_data;
                rsp_err  <= fetch_err;
            end else if (accept) begin
                pend_data <= fetch_data;
                pend_err  <= fetch_err;
            end
            if (load_from_pend) begin
                rsp_data <= pend_data;
                rsp_err  <= pend_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && ((state_q == S_STARTUP) || (state_q == S_IDLE)))
            mem[prog_addr] <= prog_data;
    end

`ifdef IMEM_RESPONDER_STATS_EN
    logic abort;
    assign abort = flush && ((state_q == S_WAIT) || (state_q == S_RESP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepts <= 32'd0;
            stat_flushes <= 32'd0;
            stat_errors  <= 32'd0;
        end else begin
            if (accept && (stat_accepts != 32'hFFFFFFFF))
                stat_accepts <= stat_accepts + 32'd1;
            if (abort && (stat_flushes != 32'hFFFFFFFF))
                stat_flushes <= stat_flushes + 32'd1;
            if (rsp_valid && rsp_err && (stat_errors != 32'hFFFFFFFF))
                stat_errors <= stat_errors + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder (WAIT_CYCLES=2 and 0)
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;

    logic        req_valid, req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr, rsp_data;
    logic        req_valid0, req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] req_addr0, rsp_data0;
`ifdef IMEM_RESPONDER_STATS_EN
    logic [31:0] st_acc, st_fl, st_err, st_acc0, st_fl0, st_err0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .STARTUP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`ifdef IMEM_RESPONDER_STATS_EN
        , .stat_accepts(st_acc), .stat_flushes(st_fl), .stat_errors(st_err)
`endif
    );

    imem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .STARTUP_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_addr(req_addr0),
        .req_ready(req_ready0), .flush(flush), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
        .rsp_err(rsp_err0), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`ifdef IMEM_RESPONDER_STATS_EN
        , .stat_accepts(st_acc0), .stat_flushes(st_fl0), .stat_errors(st_err0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        prog_we    = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic exp_e, input logic pw, input logic [9:0] pa,
                         input logic [31:0] pd);
        next_cycle();
        req_valid = 1'b1;
        req_addr  = addr;
        prog_we   = pw;
        prog_addr = pa;
        prog_data = pd;
        #1 check({tag, "_ready"}, req_ready, 1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            #1 check($sformatf("%s_valid_c%0d", tag, k), rsp_valid, (k == 3));
        end
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_err"}, rsp_err, exp_e);
        next_cycle();
        #1 check({tag, "_valid_after"}, rsp_valid, 0);
        check({tag, "_hold"}, rsp_data, exp_d);
    endtask

    task automatic prog(input logic [9:0] a, input logic [31:0] d);
        next_cycle();
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_valid = 1'b1; req_addr = 32'h0; req_valid0 = 1'b0; req_addr0 = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_err", rsp_err, 0);
`ifdef IMEM_RESPONDER_STATS_EN
        check("rst_stat_acc", st_acc, 0);
        check("rst_stat_fl", st_fl, 0);
        check("rst_stat_err", st_err, 0);
`endif

        // Startup with req_valid held; indices 0..3 loaded during STARTUP
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) next_cycle();
            rst_n     = 1'b1;
            req_valid = (c <= 7);
            req_addr  = 32'h0;
            prog_we   = (c < 4);
            prog_addr = 10'(c);
            prog_data = 32'hA0000000 + 32'(c);
            #1;
            check($sformatf("start_ready_c%0d", c), req_ready, (c == 4 || c == 7 || c == 10));
            check($sformatf("start_valid_c%0d", c), rsp_valid, (c == 7 || c == 10));
            if (c == 7 || c == 10) check($sformatf("start_data_c%0d", c), rsp_data, 32'hA0000000);
        end

        // Zero-wait instance, back-to-back
        next_cycle(); req_valid0 = 1'b1; req_addr0 = 32'h0;
        #1 check("z_ready0", req_ready0, 1);
        check("z_valid0", rsp_valid0, 0);
        next_cycle(); req_valid0 = 1'b1; req_addr0 = 32'h4;
        #1 check("z_valid1", rsp_valid0, 1);
        check("z_data1", rsp_data0, 32'hA0000000);
        check("z_ready1", req_ready0, 1);
        next_cycle(); req_valid0 = 1'b1; req_addr0 = 32'h8;
        #1 check("z_valid2", rsp_valid0, 1);
        check("z_data2", rsp_data0, 32'hA0000001);
        next_cycle();
        #1 check("z_valid3", rsp_valid0, 1);
        check("z_data3", rsp_data0, 32'hA0000002);
        check("z_err3", rsp_err0, 0);
        next_cycle();
        #1 check("z_valid4", rsp_valid0, 0);
        check("z_hold4", rsp_data0, 32'hA0000002);

        prog(10'd5, 32'hDEADBEEF);
        prog(10'd4, 32'hCAFEF00D);
        fetch("beef", 32'h14, 32'hDEADBEEF, 1'b0, 1'b0, 10'd0, 32'd0);
        fetch("same_cyc", 32'h4, 32'hA0000001, 1'b0, 1'b1, 10'd1, 32'h11111111);
        fetch("after_wr", 32'h4, 32'h11111111, 1'b0, 1'b0, 10'd0, 32'd0);
        fetch("mis", 32'h2, 32'h00000013, 1'b1, 1'b0, 10'd0, 32'd0);
        fetch("oor", 32'h1000, 32'h00000013, 1'b1, 1'b0, 10'd0, 32'd0);

        // Flush during WAIT
        next_cycle(); req_valid = 1'b1; req_addr = 32'h10;
        #1 check("fw_ready", req_ready, 1);
        next_cycle(); flush = 1'b1;
        #1 check("fw_valid_f", rsp_valid, 0);
        check("fw_ready_f", req_ready, 0);
        next_cycle();
        #1 check("fw_ready_after", req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_cycle();
            #1 check($sformatf("fw_novalid_%0d", k), rsp_valid, 0);
        end
        fetch("fw_next", 32'h10, 32'hCAFEF00D, 1'b0, 1'b0, 10'd0, 32'd0);

        // Flush in RESP gates rsp_valid and blocks the concurrent request
        next_cycle(); req_valid = 1'b1; req_addr = 32'h0;
        #1 check("fr_ready", req_ready, 1);
        next_cycle(); next_cycle();
        next_cycle(); flush = 1'b1; req_valid = 1'b1; req_addr = 32'h14;
        #1 check("fr_valid_gated", rsp_valid, 0);
        check("fr_ready_f", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1 check($sformatf("fr_novalid_%0d", k), rsp_valid, 0);
            if (k == 0) check("fr_ready_after", req_ready, 1);
        end

        // Flush in IDLE blocks acceptance
        next_cycle(); flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        #1 check("fi_ready", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1 check($sformatf("fi_novalid_%0d", k), rsp_valid, 0);
        end

        // Reset pulsed during WAIT
        next_cycle(); req_valid = 1'b1; req_addr = 32'h14;
        #1 check("rw_ready", req_ready, 1);
        next_cycle();
        rst_n = 1'b0;
        #1 check("rw_valid", rsp_valid, 0);
        check("rw_data", rsp_data, 0);
        check("rw_err", rsp_err, 0);
        check("rw_ready_rst", req_ready, 0);
`ifdef IMEM_RESPONDER_STATS_EN
        check("rw_stat_acc", st_acc, 0);
        check("rw_stat_fl", st_fl, 0);
        check("rw_stat_err", st_err, 0);
`endif
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            rst_n = 1'b1;
            #1 check($sformatf("rw_ready_c%0d", c), req_ready, (c == 4 || c == 5));
            check($sformatf("rw_novalid_c%0d", c), rsp_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
